// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator: mode encodings,
// counter direction and the duty-bus slicing helper.
package pwm_pkg;
  localparam logic PWM_MODE_EDGE   = 1'b0;
  localparam logic PWM_MODE_CENTER = 1'b1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} pwm_dir_e;

  // LSB of channel k inside the flattened duty bus
  function automatic int duty_lsb(input int k, input int width);
    return k * width;
  endfunction
endpackage

// File: rtl/pwm_chan_cmp.sv
// One PWM compare unit: registered (cnt < duty) with polarity, parked at the
// inactive level while the block is disabled.
module pwm_chan_cmp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_pol,
  input  logic             i_en,
  output logic             o_pwm
);
  logic r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_pwm <= 1'b0;
    else if (!i_en) r_pwm <= i_pol;
    else            r_pwm <= (i_cnt < i_duty) ^ i_pol;
  end

  assign o_pwm = r_pwm;
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned period counter, double-
// buffered period/duty/mode/pol, and CHANNELS compare units.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      load,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       pol,
  output logic [CHANNELS-1:0]       pwm,
  output logic                      cycle_start,
  output logic                      pending
);
  logic [WIDTH-1:0]          r_cnt;
  pwm_dir_e                  r_dir;
  logic                      r_cycle_start, r_pending;
  logic [WIDTH-1:0]          r_sh_period, r_period;
  logic [CHANNELS*WIDTH-1:0] r_sh_duty, r_duty;
  logic                      r_sh_mode, r_mode;
  logic [CHANNELS-1:0]       r_sh_pol, r_pol;

  logic [WIDTH-1:0]          w_cnt_nxt;
  pwm_dir_e                  w_dir_nxt;
  logic                      w_wrap, w_xfer, w_ld_now;
  logic [CHANNELS-1:0]       w_pol_nxt, w_pol_sel;

  always_comb begin
    w_cnt_nxt = '0;
    w_dir_nxt = DIR_UP;
    // period 0 and en=0 both leave the counter parked at 0
    if (en && r_period != '0) begin
      if (r_mode == PWM_MODE_CENTER) begin
        if (r_dir == DIR_UP && r_cnt != r_period) begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end else begin
          w_cnt_nxt = r_cnt - WIDTH'(1);
          w_dir_nxt = (w_cnt_nxt == '0) ? DIR_UP : DIR_DOWN;
        end
      end else begin
        w_cnt_nxt = (r_cnt == r_period) ? '0 : r_cnt + WIDTH'(1);
      end
    end
  end

  // A load on a boundary edge bypasses the shadow so it is never a period late
  assign w_wrap    = en && (w_cnt_nxt == '0);
  assign w_xfer    = w_wrap || !en;
  assign w_ld_now  = load && w_xfer;
  assign w_pol_nxt = w_ld_now ? pol : ((r_pending && w_xfer) ? r_sh_pol : r_pol);
  assign w_pol_sel = en ? r_pol : w_pol_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_dir         <= DIR_UP;
      r_cycle_start <= 1'b0;
      r_pending     <= 1'b0;
      r_sh_period   <= '0;
      r_sh_duty     <= '0;
      r_sh_mode     <= PWM_MODE_EDGE;
      r_sh_pol      <= '0;
      r_period      <= '0;
      r_duty        <= '0;
      r_mode        <= PWM_MODE_EDGE;
      r_pol         <= '0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_dir         <= w_dir_nxt;
      r_cycle_start <= en && (r_cnt == '0);
      if (load) begin
        r_sh_period <= period;
        r_sh_duty   <= duty;
        r_sh_mode   <= mode;
        r_sh_pol    <= pol;
      end
      if (w_ld_now) begin
        r_period  <= period;
        r_duty    <= duty;
        r_mode    <= mode;
        r_pol     <= pol;
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end else if (r_pending && w_xfer) begin
        r_period  <= r_sh_period;
        r_duty    <= r_sh_duty;
        r_mode    <= r_sh_mode;
        r_pol     <= r_sh_pol;
        r_pending <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    pwm_chan_cmp #(.WIDTH(WIDTH)) u_cmp (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_cnt  (r_cnt),
      .i_duty (r_duty[duty_lsb(k, WIDTH) +: WIDTH]),
      .i_pol  (w_pol_sel[k]),
      .i_en   (en),
      .o_pwm  (pwm[k])
    );
  end

  assign cycle_start = r_cycle_start;
  assign pending     = r_pending;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (WIDTH=8, CHANNELS=2): expected pwm/cycle_start
// samples are queued as each step is driven and popped after the clock edge.
module tb_pwm_multi;
  localparam int W = 8;
  localparam int C = 2;

  logic         clk = 1'b0, clk_run = 1'b1;
  logic         rst_n = 1'b1, en = 1'b0, load = 1'b0, mode = 1'b0;
  logic [W-1:0] period = '0;
  logic [C*W-1:0] duty = '0;
  logic [C-1:0] pol = '0;
  logic [C-1:0] pwm;
  logic         cycle_start, pending;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string        tag;
    logic [C-1:0] pwm;
    logic         cs;
  } exp_t;
  exp_t sb[$];

  pwm_multi #(.WIDTH(W), .CHANNELS(C)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .period(period),
    .duty(duty), .mode(mode), .pol(pol), .pwm(pwm),
    .cycle_start(cycle_start), .pending(pending)
  );

  always #5 if (clk_run) clk = ~clk;

  task automatic step(input string tag, input logic [C-1:0] ep, input logic ecs);
    exp_t e;
    sb.push_back('{tag, ep, ecs});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_assert++;
    assert ({pwm, cycle_start} === {e.pwm, e.cs}) else begin
      n_fail++;
      $error("FAIL %s: pwm/cs got %b/%b want %b/%b", e.tag, pwm, cycle_start, e.pwm, e.cs);
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, obs, exp_v);
    end
  endtask

  // channel 1 duty is always 0, so pwm[1] doubles as a constant-0 check
  task automatic cfg(input logic [W-1:0] p, input logic [W-1:0] d0, input logic m,
                     input logic [C-1:0] pl);
    period = p;
    duty   = {W'(0), d0};
    mode   = m;
    pol    = pl;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_pwm0", pwm[0], 1'b0);
    chk("rst_pwm1", pwm[1], 1'b0);
    chk("rst_cs", cycle_start, 1'b0);
    chk("rst_pend", pending, 1'b0);
    rst_n = 1'b1;

    // edge mode, period 3, duty 2
    cfg(3, 2, 1'b0, 2'b00); load = 1'b1;
    step("t1_load", 2'b00, 1'b0);
    chk("t1_pend", pending, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int p = 0; p < 3; p++) begin
      step("t1_c0", 2'b01, 1'b1);
      step("t1_c1", 2'b01, 1'b0);
      step("t1_c2", 2'b00, 1'b0);
      step("t1_c3", 2'b00, 1'b0);
    end

    // mid-period duty update waits for the wrap
    step("t3_c0", 2'b01, 1'b1);
    cfg(3, 1, 1'b0, 2'b00); load = 1'b1;
    step("t3_keep_c1", 2'b01, 1'b0);
    load = 1'b0;
    chk("t3_pend_set", pending, 1'b1);
    step("t3_c2", 2'b00, 1'b0);
    chk("t3_pend_hold", pending, 1'b1);
    step("t3_c3", 2'b00, 1'b0);
    chk("t3_pend_clr", pending, 1'b0);
    step("t3_n0", 2'b01, 1'b1);
    step("t3_n1", 2'b00, 1'b0);
    step("t3_n2", 2'b00, 1'b0);
    step("t3_n3", 2'b00, 1'b0);

    // period change loaded on the wrap edge applies immediately
    step("t6_c0", 2'b01, 1'b1);
    step("t6_c1", 2'b00, 1'b0);
    step("t6_c2", 2'b00, 1'b0);
    cfg(5, 1, 1'b0, 2'b00); load = 1'b1;
    step("t6_wrap", 2'b00, 1'b0);
    load = 1'b0;
    chk("t6_pend", pending, 1'b0);
    for (int p = 0; p < 2; p++) begin
      step("t6_p0", 2'b01, 1'b1);
      for (int i = 1; i <= 5; i++) step("t6_pn", 2'b00, 1'b0);
    end

    // center mode, period 3, duty 2
    en = 1'b0;
    cfg(3, 2, 1'b1, 2'b00); load = 1'b1;
    step("t2_load", 2'b00, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      step("t2_c0", 2'b01, 1'b1);
      step("t2_c1", 2'b01, 1'b0);
      step("t2_c2u", 2'b00, 1'b0);
      step("t2_c3", 2'b00, 1'b0);
      step("t2_c2d", 2'b00, 1'b0);
      step("t2_c1d", 2'b01, 1'b0);
    end

    // period 0, duty 1: constant high, every clock is a wrap
    en = 1'b0;
    cfg(0, 1, 1'b0, 2'b00); load = 1'b1;
    step("t4a_load", 2'b00, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) step("t4a_hi", 2'b01, 1'b1);

    // duty 0 loaded while running at period 0
    cfg(0, 0, 1'b0, 2'b00); load = 1'b1;
    step("t4b_edge", 2'b01, 1'b1);
    load = 1'b0;
    chk("t4b_pend", pending, 1'b0);
    for (int i = 0; i < 3; i++) step("t4b_lo", 2'b00, 1'b1);

    // duty above period: constant high
    cfg(3, 5, 1'b0, 2'b00); load = 1'b1;
    step("t4c_edge", 2'b00, 1'b1);
    load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step("t4c_c0", 2'b01, 1'b1);
      for (int i = 1; i <= 3; i++) step("t4c_cn", 2'b01, 1'b0);
    end

    // full-range period: one low clock per 256
    en = 1'b0;
    cfg(255, 255, 1'b0, 2'b00); load = 1'b1;
    step("t4d_load", 2'b00, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int i = 0; i <= 256; i++)
      step("t4d", ((i % 256) != 255) ? 2'b01 : 2'b00, (i % 256) == 0);

    // inverted polarity, idle level, then async reset with the clock stopped
    en = 1'b0;
    cfg(3, 2, 1'b0, 2'b01); load = 1'b1;
    step("t5_pol_now", 2'b01, 1'b0);
    load = 1'b0;
    step("t5_idle", 2'b01, 1'b0);
    en = 1'b1;
    step("t5_c0", 2'b00, 1'b1);
    step("t5_c1", 2'b00, 1'b0);
    cfg(1, 1, 1'b1, 2'b00); load = 1'b1;
    step("t5_c2", 2'b01, 1'b0);
    load = 1'b0;
    chk("t5_pend_pre", pending, 1'b1);
    clk_run = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_pwm0", pwm[0], 1'b0);
    chk("t5_rst_cs", cycle_start, 1'b0);
    chk("t5_rst_pend", pending, 1'b0);
    #3 rst_n = 1'b1;
    #6 clk_run = 1'b1;
    step("t5_after_rst", 2'b00, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog expired");
  end
endmodule
